// File: rtl/sf_term_line_scheduler.sv
// rtl/sf_term_line_scheduler.sv - refresh scheduler that ships the terminal line to UART TX and latches LCD text
module sf_term_line_scheduler #(
  parameter int parm_line_chars     = 35,
  parameter int parm_refresh_cycles = 4_000_000
) (
  input  logic                         i_clk_40mhz,
  input  logic                         i_rst_40mhz,
  input  logic [parm_line_chars*8-1:0] i_term_ascii_line,
  input  logic [127:0]                 i_lcd_ascii_line1,
  input  logic [127:0]                 i_lcd_ascii_line2,
  input  logic                         i_force_refresh,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic [127:0]                 o_lcd_line1,
  output logic [127:0]                 o_lcd_line2,
  output logic                         o_lcd_update,
  output logic                         o_busy,
  output logic [15:0]                  o_lines_sent
);

  localparam int LW = parm_line_chars * 8;
  localparam int IW = (parm_line_chars > 1) ? $clog2(parm_line_chars) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(parm_line_chars - 1);
  localparam logic [31:0] RELOAD = 32'(parm_refresh_cycles - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SNAPSHOT, ST_SEND, ST_DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     timer;
  logic            tick;
  logic            req, req_force, snap_force, first_pass;
  logic [LW-1:0]   snap, last_sent;
  logic [IW-1:0]   idx;
  logic            send_now, lcd_changed, leave_idle;
  logic [7:0]      line_bytes [2**IW];

  // Byte 0 is the leftmost character, held in the top byte of the snapshot.
  for (genvar g = 0; g < 2**IW; g++) begin : g_bytes
    if (g < parm_line_chars) begin : g_used
      assign line_bytes[g] = snap[LW-1-8*g -: 8];
    end else begin : g_pad
      assign line_bytes[g] = 8'h00;
    end
  end

  assign tick        = (timer == '0);
  assign leave_idle  = (state == ST_IDLE) && req;
  assign send_now    = first_pass || snap_force || (i_term_ascii_line != last_sent);
  assign lcd_changed = first_pass || (i_lcd_ascii_line1 != o_lcd_line1) ||
                       (i_lcd_ascii_line2 != o_lcd_line2);

  always_ff @(posedge i_clk_40mhz) begin
    if (i_rst_40mhz) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_tx_valid   = 1'b0;
    o_tx_data    = 8'h00;
    o_lcd_update = 1'b0;
    o_busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (req) state_nxt = ST_SNAPSHOT;
      end
      ST_SNAPSHOT: begin
        o_lcd_update = lcd_changed;
        state_nxt    = send_now ? ST_SEND : ST_IDLE;
      end
      ST_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = line_bytes[idx];
        if (i_tx_ready && (idx == LAST_IDX)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_40mhz) begin
    if (i_rst_40mhz) begin
      timer        <= RELOAD;
      req          <= 1'b0;
      req_force    <= 1'b0;
      snap_force   <= 1'b0;
      first_pass   <= 1'b1;
      snap         <= '0;
      last_sent    <= '0;
      idx          <= '0;
      o_lines_sent <= 16'h0000;
      o_lcd_line1  <= '0;
      o_lcd_line2  <= '0;
    end else begin
      timer <= tick ? RELOAD : timer - 32'd1;

      // A force landing on the departure edge still belongs to this snapshot.
      if (leave_idle) begin
        req        <= 1'b0;
        req_force  <= 1'b0;
        snap_force <= req_force | i_force_refresh;
      end else begin
        if (tick || i_force_refresh) req <= 1'b1;
        if (i_force_refresh)         req_force <= 1'b1;
      end

      case (state)
        ST_SNAPSHOT: begin
          snap        <= i_term_ascii_line;
          o_lcd_line1 <= i_lcd_ascii_line1;
          o_lcd_line2 <= i_lcd_ascii_line2;
          first_pass  <= 1'b0;
          idx         <= '0;
        end
        ST_SEND: begin
          if (i_tx_ready) idx <= idx + 1'b1;
        end
        ST_DONE: begin
          last_sent    <= snap;
          o_lines_sent <= o_lines_sent + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
